regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-bank write-port arbiter for two writeback requesters (ALU, load).
// Each requester has a one-entry buffer; an age/round-robin rule picks one per cycle.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_WIDTH-1:0]      a_reg,
  input  logic [DATA_WIDTH-1:0]      a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      b_reg,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       reg_write,
  output logic [ADDR_WIDTH-1:0]      write_register,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic [2**ADDR_WIDTH-1:0]   pending,
  output logic [7:0]                 drop_count
);

  logic                  a_full, b_full;
  logic                  a_old, b_old;
  logic [ADDR_WIDTH-1:0] a_reg_q, b_reg_q;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
  logic                  prefer_b;

  logic grant_a, grant_b, tie;
  logic a_fire, b_fire, a_load, b_load, a_drop, b_drop;
  logic [8:0] drop_sum;

  // Oldest full buffer wins; same-edge loads fall back to the round-robin pointer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    tie     = a_full && b_full && !a_old && !b_old;
    if (a_full && b_full) begin
      if (a_old)         grant_a = 1'b1;
      else if (b_old)    grant_b = 1'b1;
      else if (prefer_b) grant_b = 1'b1;
      else               grant_a = 1'b1;
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  // Handshake: a transfer happens on a rising edge where x_valid && x_ready;
  // x_ready is high when the buffer is empty or is being drained this cycle,
  // never while reset is asserted, and does not depend on x_valid.
  assign a_ready = !reset && (!a_full || grant_a);
  assign b_ready = !reset && (!b_full || grant_b);

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign a_load = a_fire && (a_reg != '0);
  assign b_load = b_fire && (b_reg != '0);
  assign a_drop = a_fire && (a_reg == '0);
  assign b_drop = b_fire && (b_reg == '0);

  assign drop_sum = {1'b0, drop_count} + 9'(a_drop) + 9'(b_drop);

  // A buffer becomes "old" when the other side loads while it keeps waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_full   <= 1'b0;
      a_old    <= 1'b0;
      a_reg_q  <= '0;
      a_data_q <= '0;
    end else if (a_load) begin
      a_full   <= 1'b1;
      a_old    <= 1'b0;
      a_reg_q  <= a_reg;
      a_data_q <= a_data;
    end else if (grant_a) begin
      a_full   <= 1'b0;
      a_old    <= 1'b0;
    end else if (a_full && b_load) begin
      a_old    <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_full   <= 1'b0;
      b_old    <= 1'b0;
      b_reg_q  <= '0;
      b_data_q <= '0;
    end else if (b_load) begin
      b_full   <= 1'b1;
      b_old    <= 1'b0;
      b_reg_q  <= b_reg;
      b_data_q <= b_data;
    end else if (grant_b) begin
      b_full   <= 1'b0;
      b_old    <= 1'b0;
    end else if (b_full && a_load) begin
      b_old    <= 1'b1;
    end
  end

  // The pointer only moves on tie-resolved grants, so solo grants leave it alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prefer_b <= 1'b0;
    end else if (tie) begin
      prefer_b <= grant_a;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      reg_write <= grant_a || grant_b;
      if (grant_a) begin
        write_register <= a_reg_q;
        write_data     <= a_data_q;
      end else if (grant_b) begin
        write_register <= b_reg_q;
        write_data     <= b_data_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else begin
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_comb begin
    pending = '0;
    if (a_full)    pending[a_reg_q]        = 1'b1;
    if (b_full)    pending[b_reg_q]        = 1'b1;
    if (reg_write) pending[write_register] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: timestamp-based model, per-cycle compare,
// a scoreboard of accepted writes, and literal scenario expectations.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_reg = '0, b_reg = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          reg_write;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic [NR-1:0] pending;
  logic [7:0]    drop_count;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .pending(pending), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: each held write carries the edge number it was accepted on.
  bit            m_held[2];
  logic [AW-1:0] m_reg[2];
  logic [DW-1:0] m_data[2];
  int            m_stamp[2];
  bit            m_pref_b;
  bit            m_out_v;
  logic [AW-1:0] m_out_reg;
  logic [DW-1:0] m_out_data;
  int            m_drops;
  int            m_edge;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    log_reg[$];
  logic [DW-1:0]    log_data[$];

  logic [AW-1:0] s3_r[5];
  logic [DW-1:0] s3_d[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_held[0] && m_held[1]) begin
      if (m_stamp[0] < m_stamp[1]) return 0;
      if (m_stamp[1] < m_stamp[0]) return 1;
      return m_pref_b ? 1 : 0;
    end
    if (m_held[0]) return 0;
    if (m_held[1]) return 1;
    return -1;
  endfunction

  function automatic bit model_ready(input int p);
    return !m_held[p] || (model_grant() == p);
  endfunction

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] p;
    p = '0;
    for (int i = 0; i < 2; i++) if (m_held[i]) p[m_reg[i]] = 1'b1;
    if (m_out_v) p[m_out_reg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 1'b0; m_stamp[i] = 0;
    end
    m_pref_b = 1'b0; m_out_v = 1'b0; m_drops = 0; m_edge = 0;
    exp_q.delete();
  endtask

  task automatic accept(input int p, input bit fire, input logic [AW-1:0] r, input logic [DW-1:0] d);
    if (!fire) return;
    if (r == '0) begin
      m_drops++;
    end else begin
      m_held[p] = 1'b1; m_reg[p] = r; m_data[p] = d; m_stamp[p] = m_edge;
      exp_q.push_back({r, d});
    end
  endtask

  task automatic model_step();
    int g;
    bit tie, fa, fb;
    if (reset) return;
    g   = model_grant();
    tie = m_held[0] && m_held[1] && (m_stamp[0] == m_stamp[1]);
    fa  = a_valid && (!m_held[0] || g == 0);
    fb  = b_valid && (!m_held[1] || g == 1);
    m_out_v = (g >= 0);
    if (g >= 0) begin
      m_out_reg  = m_reg[g];
      m_out_data = m_data[g];
      m_held[g]  = 1'b0;
      if (tie) m_pref_b = (g == 0);
    end
    accept(0, fa, a_reg, a_data);
    accept(1, fb, b_reg, b_data);
    m_edge++;
  endtask

  // Per-cycle compare against the model, plus scoreboard retirement of each write.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("a_ready", 64'(a_ready), 64'(model_ready(0)));
      chk("b_ready", 64'(b_ready), 64'(model_ready(1)));
      chk("reg_write", 64'(reg_write), 64'(m_out_v));
      chk("pending", 64'(pending), 64'(model_pending()));
      chk("drop_count", 64'(drop_count), 64'((m_drops > 255) ? 255 : m_drops));
      if (m_out_v) begin
        chk("write_register", 64'(write_register), 64'(m_out_reg));
        chk("write_data", 64'(write_data), 64'(m_out_data));
      end
      if (reg_write) begin
        int found;
        found = -1;
        log_reg.push_back(write_register);
        log_data.push_back(write_data);
        for (int k = 0; k < exp_q.size(); k++) begin
          if (exp_q[k][AW+DW-1:DW] == write_register) begin
            found = k;
            break;
          end
        end
        chk("sb_found", 64'(found >= 0), 64'(1));
        if (found >= 0) begin
          chk("sb_order", 64'(write_data), 64'(exp_q[found][DW-1:0]));
          exp_q.delete(found);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #2;
  endtask

  task automatic drive(input bit av, input int ar, input logic [DW-1:0] ad,
                       input bit bv, input int br, input logic [DW-1:0] bd);
    a_valid = av; a_reg = AW'(ar); a_data = ad;
    b_valid = bv; b_reg = AW'(br); b_data = bd;
  endtask

  task automatic idle(input int n);
    drive(0, 0, '0, 0, 0, '0);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    model_reset();
    log_reg.delete(); log_data.delete();
    tick();
    chk("rst_a_ready", 64'(a_ready), 64'(0));
    chk("rst_b_ready", 64'(b_ready), 64'(0));
    chk("rst_reg_write", 64'(reg_write), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_drop_count", 64'(drop_count), 64'(0));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    s3_r[0] = 5'd3; s3_r[1] = 5'd7; s3_r[2] = 5'd5; s3_r[3] = 5'd4; s3_r[4] = 5'd4;
    s3_d[0] = 32'h1; s3_d[1] = 32'h2; s3_d[2] = 32'h3; s3_d[3] = 32'h5; s3_d[4] = 32'h6;

    // Single write: A reg 8 = 0xAA.
    do_reset();
    drive(1, 8, 32'h0000_00AA, 0, 0, '0);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    chk("s1_pend8_e1", 64'(pending[8]), 64'(1));
    chk("s1_rw_e1", 64'(reg_write), 64'(0));
    tick();
    chk("s1_rw_e2", 64'(reg_write), 64'(1));
    chk("s1_reg_e2", 64'(write_register), 64'(8));
    chk("s1_data_e2", 64'(write_data), 64'(32'hAA));
    tick();
    chk("s1_pend_e3", 64'(pending), 64'(0));
    chk("s1_rw_e3", 64'(reg_write), 64'(0));
    idle(2);

    // Contention: same-edge ties alternate starting with A.
    do_reset();
    drive(1, 9, 32'h11, 1, 10, 32'h22);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    chk("s2_a_ready", 64'(a_ready), 64'(1));
    chk("s2_b_ready", 64'(b_ready), 64'(0));
    tick();
    chk("s2_first_reg", 64'(write_register), 64'(9));
    chk("s2_first_data", 64'(write_data), 64'(32'h11));
    tick();
    chk("s2_second_reg", 64'(write_register), 64'(10));
    chk("s2_second_data", 64'(write_data), 64'(32'h22));
    drive(1, 9, 32'h33, 1, 10, 32'h44);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    tick();
    chk("s2_tie2_first_reg", 64'(write_register), 64'(10));
    chk("s2_tie2_first_data", 64'(write_data), 64'(32'h44));
    tick();
    chk("s2_tie2_second_reg", 64'(write_register), 64'(9));
    chk("s2_tie2_second_data", 64'(write_data), 64'(32'h33));
    idle(2);

    // Age: B reg 4 accepted one edge before A reg 4 while both queues are busy.
    do_reset();
    drive(1, 3, 32'h1, 1, 7, 32'h2);
    tick();
    drive(1, 5, 32'h3, 0, 0, '0);
    tick();
    drive(0, 0, '0, 1, 4, 32'h5);
    tick();
    drive(1, 4, 32'h6, 0, 0, '0);
    tick();
    idle(5);
    chk("s3_count", 64'(log_reg.size()), 64'(5));
    if (log_reg.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("s3_seq_reg", 64'(log_reg[i]), 64'(s3_r[i]));
        chk("s3_seq_data", 64'(log_data[i]), 64'(s3_d[i]));
      end
    end

    // Register-0 drops: double drop then saturation.
    do_reset();
    drive(1, 0, 32'hFFFF_FFFF, 1, 0, 32'h1234);
    tick();
    chk("s4_double_drop", 64'(drop_count), 64'(2));
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, '0);
    repeat (300) tick();
    chk("s4_a_ready", 64'(a_ready), 64'(1));
    idle(3);
    chk("s4_saturated", 64'(drop_count), 64'(255));
    chk("s4_no_writes", 64'(log_reg.size()), 64'(0));

    // Backpressure: both ports valid every cycle.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1, 1 + (i % 11), 32'hA000_0000 + 32'(i), 1, 12 + (i % 4), 32'hB000_0000 + 32'(i));
      tick();
    end
    idle(6);
    chk("s5_write_count", 64'(log_reg.size()), 64'(41));
    if (log_reg.size() >= 2) begin
      chk("s5_first_reg", 64'(log_reg[0]), 64'(1));
      chk("s5_first_data", 64'(log_data[0]), 64'(32'hA000_0000));
      chk("s5_second_reg", 64'(log_reg[1]), 64'(12));
      chk("s5_second_data", 64'(log_data[1]), 64'(32'hB000_0000));
    end
    chk("s5_drained", 64'(exp_q.size()), 64'(0));

    // Reset mid-operation: outputs clear without a clock edge.
    do_reset();
    drive(1, 2, 32'hCAFE_0002, 1, 3, 32'hCAFE_0003);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    tick();
    chk("s6_busy_before", 64'(reg_write), 64'(1));
    reset = 1'b1;
    model_reset();
    log_reg.delete(); log_data.delete();
    #1;
    chk("s6_rw_async", 64'(reg_write), 64'(0));
    chk("s6_reg_async", 64'(write_register), 64'(0));
    chk("s6_data_async", 64'(write_data), 64'(0));
    chk("s6_pend_async", 64'(pending), 64'(0));
    chk("s6_ready_async", 64'({a_ready, b_ready}), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    idle(6);
    chk("s6_no_write_after", 64'(log_reg.size()), 64'(0));

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
